// File: rtl/network_pkg.sv
// network_pkg -- shared constants, stream indices and LFSR seed derivation for bitstream_network.
`default_nettype none

package network_pkg;

  localparam int             LFSR_W       = 8;
  localparam logic [7:0]     TAP_MASK     = 8'hB8;   // x^8+x^6+x^5+x^4+1
  localparam int             NUM_INPUTS   = 2;
  localparam int             NUM_OUTPUTS  = 1;
  localparam int             NUM_STREAMS  = 6;
  localparam int             BIPOLAR_ZERO = 128;
  localparam int             FULL_SCALE   = 256;

  typedef enum logic [2:0] {
    STR_X0   = 3'd0,
    STR_X1   = 3'd1,
    STR_W0   = 3'd2,
    STR_W1   = 3'd3,
    STR_BIAS = 3'd4,
    STR_SEL  = 3'd5
  } stream_e;

  function automatic logic [7:0] derive_seed(input logic [7:0] base, input int k);
    logic [7:0] v;
    v = base ^ 8'(8'h1D * k);
    for (int i = 0; i < (k % 8); i++) begin
      v = {v[6:0], v[7]};
    end
    if (v == 8'h00) v = 8'h01;   // an all-zero LFSR would lock up
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_stream_gen.sv
// sc_stream_gen -- 8-bit Fibonacci LFSR plus comparator producing a probability-coded bitstream.
`default_nettype none

module sc_stream_gen
  import network_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                i_en,
  input  logic signed [31:0]  i_value,
  output logic                o_bit,
  output logic [LFSR_W-1:0]   o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;
  logic [8:0]        w_level;

  assign w_fb = ^(r_lfsr & TAP_MASK);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

  always_comb begin
    w_level = i_value[8:0];
    if (i_value < 0) begin
      w_level = 9'd0;
    end else if (i_value > FULL_SCALE) begin
      w_level = 9'(FULL_SCALE);
    end
  end

  // The extra MSB lets code 256 exceed every LFSR value, giving an all-ones stream.
  assign o_bit  = ({1'b0, r_lfsr} < w_level);
  assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/bitstream_network.sv
// bitstream_network -- 2-input stochastic-computing neuron with windowed ones-count readout.
// Define NETWORK_STANH_EN for the saturating-counter tanh activation; otherwise the neuron is linear.
`default_nettype none

module bitstream_network
  import network_pkg::*;
#(
  parameter logic [7:0] SEED   = 8'b10001101,
  parameter int         W0     = 256,
  parameter int         W1     = 256,
  parameter int         BIAS   = 128,
  parameter int         STATES = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                compute,
  input  logic signed [31:0]  network_input  [0:NUM_INPUTS-1],
  output logic signed [31:0]  network_output [0:NUM_OUTPUTS-1]
);

  logic signed [31:0] w_level [0:NUM_STREAMS-1];
  logic               w_bit   [0:NUM_STREAMS-1];
  logic [LFSR_W-1:0]  w_lfsr  [0:NUM_STREAMS-1];

  assign w_level[int'(STR_X0)]   = network_input[0];
  assign w_level[int'(STR_X1)]   = network_input[1];
  assign w_level[int'(STR_W0)]   = W0;
  assign w_level[int'(STR_W1)]   = W1;
  assign w_level[int'(STR_BIAS)] = BIAS;
  assign w_level[int'(STR_SEL)]  = 32'sd0;

  genvar k;
  generate
    for (k = 0; k < NUM_STREAMS; k++) begin : g_stream
      sc_stream_gen #(
        .SEED (derive_seed(SEED, k))
      ) u_gen (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_en    (compute),
        .i_value (w_level[k]),
        .o_bit   (w_bit[k]),
        .o_lfsr  (w_lfsr[k])
      );
    end
  endgenerate

  logic       w_p0, w_p1, w_half, w_sum, w_act;
  logic [1:0] w_sel;
  logic       r_compute_d;
  logic [31:0] r_count, r_result;

  assign w_p0   = ~(w_bit[int'(STR_X0)] ^ w_bit[int'(STR_W0)]);
  assign w_p1   = ~(w_bit[int'(STR_X1)] ^ w_bit[int'(STR_W1)]);
  assign w_half = w_lfsr[int'(STR_SEL)][7];
  assign w_sel  = w_lfsr[int'(STR_SEL)][1:0];

  // Uniform 4:1 selection realises the scaled sum (p0 + p1 + bias + 0) / 4.
  always_comb begin
    w_sum = w_half;
    case (w_sel)
      2'd0:    w_sum = w_p0;
      2'd1:    w_sum = w_p1;
      2'd2:    w_sum = w_bit[int'(STR_BIAS)];
      default: w_sum = w_half;
    endcase
  end

`ifdef NETWORK_STANH_EN
  localparam int            SW     = $clog2(STATES);
  localparam logic [SW-1:0] ST_MID = SW'(STATES / 2);
  localparam logic [SW-1:0] ST_MAX = SW'(STATES - 1);

  logic [SW-1:0] r_state, w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (compute) begin
      if (w_sum && (r_state != ST_MAX)) begin
        w_state_nxt = r_state + 1'b1;
      end else if (!w_sum && (r_state != '0)) begin
        w_state_nxt = r_state - 1'b1;
      end
    end else if (r_compute_d) begin
      w_state_nxt = ST_MID;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= ST_MID;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_act = (r_state >= ST_MID);
`else
  assign w_act = w_sum;
`endif

  // Latch once on the falling edge of compute; idle cycles after that are inert.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_compute_d <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
    end else begin
      r_compute_d <= compute;
      if (compute) begin
        r_count <= r_count + 32'(w_act);
      end else if (r_compute_d) begin
        r_result <= r_count;
        r_count  <= '0;
      end
    end
  end

  assign network_output[0] = r_result;

  logic w_unused;
  assign w_unused = ^{w_bit[int'(STR_SEL)], w_lfsr[int'(STR_X0)], w_lfsr[int'(STR_X1)],
                      w_lfsr[int'(STR_W0)], w_lfsr[int'(STR_W1)], w_lfsr[int'(STR_BIAS)],
                      w_lfsr[int'(STR_SEL)][6:2]};

endmodule

`default_nettype wire

// File: tb/tb_bitstream_network.sv
// tb_bitstream_network -- directed self-checking bench for bitstream_network.
`default_nettype none

module tb_bitstream_network;

  logic               clk = 1'b0;
  logic               n_rst = 1'b0;
  logic               compute = 1'b0;
  logic signed [31:0] network_input  [0:1];
  logic signed [31:0] network_output [0:0];

  int n_cmp = 0;
  int n_bad = 0;

`ifdef NETWORK_STANH_EN
  localparam int HI_MIN = 230, HI_MAX = 256;
  localparam int LO_MIN = 0,   LO_MAX = 26;
`else
  localparam int HI_MIN = 172, HI_MAX = 212;
  localparam int LO_MIN = 44,  LO_MAX = 84;
`endif
  localparam int MID_MIN = 88, MID_MAX = 168;

  bitstream_network dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .compute        (compute),
    .network_input  (network_input),
    .network_output (network_output)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Inputs change at negedge; compute is high for n rising edges, then one latching edge.
  task automatic run_window(input int a, input int b, input int n);
    network_input[0] = a;
    network_input[1] = b;
    compute = 1'b1;
    repeat (n) @(negedge clk);
    compute = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    network_input[0] = 0;
    network_input[1] = 0;
    n_rst   = 1'b0;
    compute = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_out", network_output[0], 0);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_out", network_output[0], 0);
    end

    network_input[0] = 256;
    network_input[1] = 256;
    compute = 1'b1;
    repeat (256) @(negedge clk);
    check_eq("held_during_window", network_output[0], 0);
    compute = 1'b0;
    @(negedge clk);
    check_rng("ones_256", network_output[0], HI_MIN, HI_MAX);
    repeat (3) @(negedge clk);
    check_rng("ones_256_held", network_output[0], HI_MIN, HI_MAX);

    run_window(0, 0, 256);
    check_rng("ones_0", network_output[0], LO_MIN, LO_MAX);

    run_window(128, 128, 256);
    check_rng("ones_128", network_output[0], MID_MIN, MID_MAX);

    run_window(256, 256, 256);
    check_rng("b2b_first", network_output[0], HI_MIN, HI_MAX);
    run_window(0, 0, 256);
    check_rng("b2b_second", network_output[0], LO_MIN, LO_MAX);

    network_input[0] = 256;
    network_input[1] = 256;
    compute = 1'b1;
    repeat (100) @(negedge clk);
    n_rst   = 1'b0;
    compute = 1'b0;
    @(negedge clk);
    check_eq("midwin_reset_out", network_output[0], 0);
    n_rst = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", network_output[0], 0);
    run_window(256, 256, 256);
    check_rng("post_reset_256", network_output[0], HI_MIN, HI_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
